// File: rtl/bsg_rx_pkg.sv
// rtl/bsg_rx_pkg.sv - shared types and interval thresholds for the FM0 receive path
// Purpose: decoder state and interval-class enums, plus helpers that derive the
//          interval class bounds from the nominal half-symbol length.
package bsg_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALF = 2'd2
  } fm0_dec_state_e;

  typedef enum logic [1:0] {
    GLITCH = 2'd0,
    SHORT  = 2'd1,
    LONG   = 2'd2
  } interval_class_e;

  // Intervals below this are too short to be a half-symbol.
  function automatic int short_min(input int half_bit);
    return half_bit / 2;
  endfunction

  // Intervals from here up are a full symbol (an FM0 '1').
  function automatic int long_min(input int half_bit);
    return (3 * half_bit) / 2;
  endfunction

  // Quiet time that ends a frame.
  function automatic int timeout_cnt(input int half_bit);
    return (5 * half_bit) / 2;
  endfunction

endpackage

// File: rtl/fm0_edge_timer.sv
// rtl/fm0_edge_timer.sv - line synchronizer, edge detector and interval classifier
// Purpose: brings line_in into the clock domain, finds level changes and measures
//          the spacing between them with a saturating counter.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   line_in     raw asynchronous line level
//   edge_o      one-cycle strobe per detected level change
//   cls_o       class of the interval that ended at edge_o
//   timeout_o   one-cycle strobe when the line has been quiet for a full timeout
// Optional: BSG_FM0_DEC_GLITCH_FILTER_EN inserts a 3-sample majority filter.
module fm0_edge_timer
  import bsg_rx_pkg::*;
#(
  parameter int HALF_BIT = 8,
  parameter int CNT_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            line_in,
  output logic            edge_o,
  output interval_class_e cls_o,
  output logic            timeout_o
);

  localparam logic [CNT_W-1:0] SHORT_MIN = CNT_W'(short_min(HALF_BIT));
  localparam logic [CNT_W-1:0] LONG_MIN  = CNT_W'(long_min(HALF_BIT));
  // Strobe fires as the counter steps onto the timeout value, so only once per gap.
  localparam logic [CNT_W-1:0] TMO_PRE   = CNT_W'(timeout_cnt(HALF_BIT) - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            line_s;
  logic            level_q, level_d;
  logic            edge_q, edge_d;
  logic            timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  interval_class_e cls_q, cls_d;

  always_comb begin
    sync1_d = line_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef BSG_FM0_DEC_GLITCH_FILTER_EN
  // Majority of the last three samples: a level must persist two clocks to pass.
  logic [1:0] hist_q, hist_d;
  logic       filt_q, filt_d;

  always_comb begin
    hist_d = {hist_q[0], sync2_q};
    filt_d = (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 2'b00;
      filt_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      filt_q <= filt_d;
    end
  end

  assign line_s = filt_q;
`else
  assign line_s = sync2_q;
`endif

  // cnt_q equals the number of clocks since the previous edge when the next one arrives.
  always_comb begin
    level_d   = line_s;
    edge_d    = line_s ^ level_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    cls_d     = LONG;
    if (cnt_q < SHORT_MIN) begin
      cls_d = GLITCH;
    end else if (cnt_q < LONG_MIN) begin
      cls_d = SHORT;
    end
    if (edge_d) begin
      cnt_d = CNT_ONE;
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end
      timeout_d = (cnt_q == TMO_PRE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= 1'b0;
      edge_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      cls_q     <= GLITCH;
    end else begin
      level_q   <= level_d;
      edge_q    <= edge_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      cls_q     <= cls_d;
    end
  end

  assign edge_o    = edge_q;
  assign cls_o     = cls_q;
  assign timeout_o = timeout_q;

endmodule

// File: rtl/fm0_decoder.sv
// rtl/fm0_decoder.sv - FM0 line decoder producing DATA_WIDTH words on a valid/ready port
// Purpose: turns classified line intervals into bits (long = 1, two shorts = 0),
//          packs them MSB first and holds each word until the consumer takes it.
// Ports:
//   G_CLK_TX    block clock
//   rst         asynchronous active-low reset
//   enable      low holds the decoder idle
//   line_in     raw FM0 line level (asynchronous)
//   DATA_OUT    held decoded word
//   data_valid  DATA_OUT holds an unconsumed word
//   data_ready  consumer accepts the word
//   frame_end   pulse when the line goes quiet after a frame
//   code_err    pulse on an FM0 violation
//   overflow    pulse when a completed word is dropped
// Optional: BSG_FM0_DEC_GLITCH_FILTER_EN (majority filter in fm0_edge_timer).
module fm0_decoder
  import bsg_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int HALF_BIT   = 8,
  parameter int CNT_W      = 8
) (
  input  logic                  G_CLK_TX,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  line_in,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  frame_end,
  output logic                  code_err,
  output logic                  overflow
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);

  logic            edge_s, tmo_s;
  interval_class_e cls_s;

  fm0_edge_timer #(
    .HALF_BIT (HALF_BIT),
    .CNT_W    (CNT_W)
  ) u_edge_timer (
    .clk       (G_CLK_TX),
    .rst_n     (rst),
    .line_in   (line_in),
    .edge_o    (edge_s),
    .cls_o     (cls_s),
    .timeout_o (tmo_s)
  );

  fm0_dec_state_e state_q, state_d;
  logic           shift_en, shift_bit, clear;
  logic           code_err_q, code_err_d;
  logic           frame_end_q, frame_end_d;

  always_ff @(posedge G_CLK_TX or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (edge_s) state_d = RUN;
        RUN: begin
          if (edge_s) begin
            if (cls_s == SHORT) begin
              state_d = HALF;
            end else if (cls_s == GLITCH) begin
              state_d = IDLE;
            end
          end else if (tmo_s) begin
            state_d = IDLE;
          end
        end
        HALF: begin
          if (edge_s) begin
            state_d = (cls_s == SHORT) ? RUN : IDLE;
          end else if (tmo_s) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // clear is asserted whenever the FSM is or goes idle, discarding partial bits.
  always_comb begin
    shift_en    = 1'b0;
    shift_bit   = 1'b0;
    clear       = 1'b0;
    code_err_d  = 1'b0;
    frame_end_d = 1'b0;
    if (!enable) begin
      clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: clear = 1'b1;
        RUN: begin
          if (edge_s) begin
            if (cls_s == LONG) begin
              shift_en  = 1'b1;
              shift_bit = 1'b1;
            end else if (cls_s == GLITCH) begin
              code_err_d = 1'b1;
              clear      = 1'b1;
            end
          end else if (tmo_s) begin
            frame_end_d = 1'b1;
            clear       = 1'b1;
          end
        end
        HALF: begin
          if (edge_s) begin
            if (cls_s == SHORT) begin
              shift_en = 1'b1;
            end else begin
              code_err_d = 1'b1;
              clear      = 1'b1;
            end
          end else if (tmo_s) begin
            code_err_d  = 1'b1;
            frame_end_d = 1'b1;
            clear       = 1'b1;
          end
        end
        default: clear = 1'b1;
      endcase
    end
  end

  // Only DATA_WIDTH-1 partial bits ever need storing; the last bit goes
  // straight into the holding register.
  logic [DATA_WIDTH-2:0] shift_q, shift_d;
  logic [BCW-1:0]        bitcnt_q, bitcnt_d;
  logic [DATA_WIDTH-1:0] next_word;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  overflow_q, overflow_d;

  always_comb begin
    next_word = {shift_q, shift_bit};
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    word_done = 1'b0;
    if (clear) begin
      shift_d  = '0;
      bitcnt_d = '0;
    end else if (shift_en) begin
      if (bitcnt_q == BIT_LAST) begin
        word_done = 1'b1;
        shift_d   = '0;
        bitcnt_d  = '0;
      end else begin
        shift_d  = next_word[DATA_WIDTH-2:0];
        bitcnt_d = bitcnt_q + BIT_ONE;
      end
    end
  end

  // A word arriving in the same cycle as a transfer replaces the outgoing one.
  always_comb begin
    dout_d     = dout_q;
    valid_d    = valid_q;
    overflow_d = 1'b0;
    if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
    if (word_done) begin
      if (!valid_q || data_ready) begin
        dout_d  = next_word;
        valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge G_CLK_TX or negedge rst) begin
    if (!rst) begin
      shift_q     <= '0;
      bitcnt_q    <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      code_err_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      code_err_q  <= code_err_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign DATA_OUT   = dout_q;
  assign data_valid = valid_q;
  assign overflow   = overflow_q;
  assign code_err   = code_err_q;
  assign frame_end  = frame_end_q;

endmodule

// File: tb/tb_fm0_decoder.sv
// tb/tb_fm0_decoder.sv - directed self-checking bench for fm0_decoder
module tb_fm0_decoder;

  localparam int H = 8;
`ifdef BSG_FM0_DEC_GLITCH_FILTER_EN
  localparam int DV_LAT = 6;
`else
  localparam int DV_LAT = 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       line_in = 1'b0;
  logic       data_ready = 1'b0;
  logic [7:0] DATA_OUT;
  logic       data_valid, frame_end, code_err, overflow;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_xfer = 0, n_fe = 0, n_ce = 0, n_ovf = 0;
  logic [7:0] last_word = 8'h00;
  logic       lvl = 1'b0;

  fm0_decoder #(
    .DATA_WIDTH (8),
    .HALF_BIT   (H),
    .CNT_W      (8)
  ) dut (
    .G_CLK_TX   (clk),
    .rst        (rst),
    .enable     (enable),
    .line_in    (line_in),
    .DATA_OUT   (DATA_OUT),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_end  (frame_end),
    .code_err   (code_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Event counters sampled mid-cycle; tests compare deltas.
  always @(negedge clk) begin
    if (data_valid && data_ready) begin
      n_xfer    <= n_xfer + 1;
      last_word <= DATA_OUT;
    end
    if (frame_end) n_fe  <= n_fe + 1;
    if (code_err)  n_ce  <= n_ce + 1;
    if (overflow)  n_ovf <= n_ovf + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic toggle();
    lvl     = ~lvl;
    line_in = lvl;
  endtask

  // FM0: edge at every bit boundary, extra mid-bit edge for '0'; ends with a boundary edge.
  task automatic send_frame(input logic [31:0] data, input int nbits, input bit jit, input int spike);
    int k;
    int j;
    k = 0;
    toggle();
    for (int i = nbits - 1; i >= 0; i--) begin
      if (data[i]) begin
        j = jit ? ((k % 2 == 1) ? -3 : 3) : 0;
        k++;
        if (i == spike) begin
          tick(7); toggle(); tick(1); toggle(); tick(8);
        end else begin
          tick(2 * H + j);
        end
        toggle();
      end else begin
        j = jit ? ((k % 2 == 1) ? -3 : 3) : 0;
        k++;
        tick(H + j);
        toggle();
        j = jit ? ((k % 2 == 1) ? -3 : 3) : 0;
        k++;
        tick(H + j);
        toggle();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(3);
    n_checks++;
    if (DATA_OUT !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_data: got %h expected 00", DATA_OUT);
    end
    n_checks++;
    if ({data_valid, frame_end, code_err, overflow} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b expected 0000", {data_valid, frame_end, code_err, overflow});
    end
    rst        = 1'b1;
    enable     = 1'b1;
    data_ready = 1'b1;
    tick(30);
  endtask

  task automatic test_nominal();
    int x0, f0, c0;
    x0 = n_xfer; f0 = n_fe; c0 = n_ce;
    send_frame(32'hA5, 8, 1'b0, -1);
    tick(DV_LAT - 1);
    n_checks++;
    if (data_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL nom_valid_early: got %b expected 0", data_valid);
    end
    tick(1);
    n_checks++;
    if (data_valid !== 1'b1 || DATA_OUT !== 8'hA5) begin
      n_errors++;
      $display("FAIL nom_word: got valid=%b data=%h expected valid=1 data=a5", data_valid, DATA_OUT);
    end
    tick(19 - DV_LAT);
    n_checks++;
    if (n_fe - f0 !== 0) begin
      n_errors++;
      $display("FAIL nom_fe_early: got %0d expected 0", n_fe - f0);
    end
    tick(11);
    n_checks++;
    if (n_fe - f0 !== 1) begin
      n_errors++;
      $display("FAIL nom_frame_end: got %0d expected 1", n_fe - f0);
    end
    n_checks++;
    if (n_xfer - x0 !== 1 || n_ce - c0 !== 0) begin
      n_errors++;
      $display("FAIL nom_counts: got xfer=%0d err=%0d expected xfer=1 err=0", n_xfer - x0, n_ce - c0);
    end
  endtask

  task automatic test_jitter();
    int x0, c0;
    x0 = n_xfer; c0 = n_ce;
    send_frame(32'h3C, 8, 1'b1, -1);
    tick(30);
    n_checks++;
    if (n_xfer - x0 !== 1 || last_word !== 8'h3C) begin
      n_errors++;
      $display("FAIL jitter_word: got xfer=%0d data=%h expected xfer=1 data=3c", n_xfer - x0, last_word);
    end
    n_checks++;
    if (n_ce - c0 !== 0) begin
      n_errors++;
      $display("FAIL jitter_err: got %0d expected 0", n_ce - c0);
    end
  endtask

  task automatic test_glitch();
    int x0, c0;
    x0 = n_xfer; c0 = n_ce;
    toggle(); tick(7); toggle(); tick(2); toggle(); tick(7); toggle();
    tick(30);
    n_checks++;
    if (n_ce - c0 !== 1 || n_xfer - x0 !== 0) begin
      n_errors++;
      $display("FAIL glitch: got err=%0d xfer=%0d expected err=1 xfer=0", n_ce - c0, n_xfer - x0);
    end
  endtask

`ifdef BSG_FM0_DEC_GLITCH_FILTER_EN
  task automatic test_filter();
    int x0, c0;
    x0 = n_xfer; c0 = n_ce;
    send_frame(32'hFF, 8, 1'b0, 7);
    tick(30);
    n_checks++;
    if (n_ce - c0 !== 0 || n_xfer - x0 !== 1 || last_word !== 8'hFF) begin
      n_errors++;
      $display("FAIL filter: got err=%0d xfer=%0d data=%h expected err=0 xfer=1 data=ff",
               n_ce - c0, n_xfer - x0, last_word);
    end
  endtask
`endif

  task automatic test_backpressure();
    int x0, o0;
    x0 = n_xfer; o0 = n_ovf;
    data_ready = 1'b0;
    send_frame(32'h112233, 24, 1'b0, -1);
    tick(30);
    n_checks++;
    if (n_ovf - o0 !== 2) begin
      n_errors++;
      $display("FAIL bp_overflow: got %0d expected 2", n_ovf - o0);
    end
    n_checks++;
    if (data_valid !== 1'b1 || DATA_OUT !== 8'h11 || n_xfer - x0 !== 0) begin
      n_errors++;
      $display("FAIL bp_hold: got valid=%b data=%h xfer=%0d expected valid=1 data=11 xfer=0",
               data_valid, DATA_OUT, n_xfer - x0);
    end
    data_ready = 1'b1;
    tick(3);
    n_checks++;
    if (n_xfer - x0 !== 1 || last_word !== 8'h11 || data_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_drain: got xfer=%0d data=%h valid=%b expected xfer=1 data=11 valid=0",
               n_xfer - x0, last_word, data_valid);
    end
  endtask

  task automatic test_half_violation();
    int x0, c0, f0;
    c0 = n_ce; f0 = n_fe;
    toggle(); tick(16); toggle(); tick(16); toggle(); tick(8); toggle(); tick(16); toggle();
    tick(30);
    n_checks++;
    if (n_ce - c0 !== 1 || n_fe - f0 !== 0) begin
      n_errors++;
      $display("FAIL half_viol: got err=%0d fe=%0d expected err=1 fe=0", n_ce - c0, n_fe - f0);
    end
    x0 = n_xfer;
    send_frame(32'hF0, 8, 1'b0, -1);
    tick(30);
    n_checks++;
    if (n_xfer - x0 !== 1 || last_word !== 8'hF0 || n_ce - c0 !== 1) begin
      n_errors++;
      $display("FAIL half_recover: got xfer=%0d data=%h err=%0d expected xfer=1 data=f0 err=1",
               n_xfer - x0, last_word, n_ce - c0);
    end
  endtask

  task automatic test_enable();
    int x0, f0, c0;
    x0 = n_xfer; f0 = n_fe; c0 = n_ce;
    enable = 1'b0;
    send_frame(32'hA5, 8, 1'b0, -1);
    tick(30);
    n_checks++;
    if (n_xfer - x0 !== 0 || n_fe - f0 !== 0 || n_ce - c0 !== 0) begin
      n_errors++;
      $display("FAIL enable_off: got xfer=%0d fe=%0d err=%0d expected 0 0 0",
               n_xfer - x0, n_fe - f0, n_ce - c0);
    end
    enable = 1'b1;
    tick(5);
  endtask

  task automatic test_reset_mid();
    int x0;
    data_ready = 1'b0;
    send_frame(32'h3C, 8, 1'b0, -1);
    tick(30);
    n_checks++;
    if (data_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL rstmid_pre: got valid=%b expected 1", data_valid);
    end
    toggle(); tick(16); toggle(); tick(8); toggle(); tick(8); toggle(); tick(16); toggle();
    tick(4);
    rst     = 1'b0;
    lvl     = 1'b0;
    line_in = 1'b0;
    #1;
    n_checks++;
    if (DATA_OUT !== 8'h00 || {data_valid, frame_end, code_err, overflow} !== 4'b0000) begin
      n_errors++;
      $display("FAIL rstmid_clear: got data=%h flags=%b expected data=00 flags=0000",
               DATA_OUT, {data_valid, frame_end, code_err, overflow});
    end
    tick(3);
    rst        = 1'b1;
    data_ready = 1'b1;
    tick(30);
    x0 = n_xfer;
    send_frame(32'h5A, 8, 1'b0, -1);
    tick(30);
    n_checks++;
    if (n_xfer - x0 !== 1 || last_word !== 8'h5A) begin
      n_errors++;
      $display("FAIL rstmid_after: got xfer=%0d data=%h expected xfer=1 data=5a", n_xfer - x0, last_word);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_jitter();
    test_glitch();
`ifdef BSG_FM0_DEC_GLITCH_FILTER_EN
    test_filter();
`endif
    test_backpressure();
    test_half_violation();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
